// File: rtl/splitmix_pkg.sv
// SplitMix64 constants and arbiter FSM state type shared by the
// splitmix_arbiter slice.
package splitmix_pkg;

  localparam logic [63:0] SM_GAMMA = 64'h9E37_79B9_7F4A_7C15;
  localparam logic [63:0] SM_MUL1  = 64'hBF58_476D_1CE4_E5B9;
  localparam logic [63:0] SM_MUL2  = 64'h94D0_49BB_1331_11EB;

  typedef enum logic {
    UNSEEDED = 1'b0,
    READY    = 1'b1
  } fsm_e;

endpackage

// File: rtl/splitmix_arbiter_core.sv
// Combinational SplitMix64 finaliser: maps an (already advanced) state
// word to its 64-bit output value.
module splitmix_core
  import splitmix_pkg::*;
(
  input  logic [63:0] x,
  output logic [63:0] z
);

  logic [63:0] s1;
  logic [63:0] s2;

  always_comb begin
    s1 = (x  ^ (x  >> 30)) * SM_MUL1;
    s2 = (s1 ^ (s1 >> 27)) * SM_MUL2;
    z  = s2 ^ (s2 >> 31);
  end

endmodule

// File: rtl/splitmix_arbiter.sv
// Round-robin arbiter that hands each granted requester a fresh SplitMix64
// value, one grant per cycle, with a single register stage of latency.
module splitmix_arbiter
  import splitmix_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter bit          AUTO_SEED = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            seed_valid,
  input  logic [63:0]     seed_data,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            rand_valid,
  output logic [63:0]     rand_data,
  output logic            seeded
);

  localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  fsm_e            fsm_q, fsm_d;
  logic [63:0]     state_q, state_d;
  logic [PTRW-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            rv_q, rv_d;
  logic [63:0]     rd_q, rd_d;

  logic [63:0]     state_adv;
  logic [63:0]     mixed;
  logic            found;
  logic [PTRW-1:0] gidx;
  int unsigned     idx;

  assign state_adv = state_q + SM_GAMMA;

  splitmix_core u_core (
    .x (state_adv),
    .z (mixed)
  );

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    rv_d    = 1'b0;
    rd_d    = rd_q;
    found   = 1'b0;
    gidx    = '0;
    idx     = 0;

    // Seed load takes priority and blocks arbitration for the cycle.
    if (seed_valid) begin
      state_d = seed_data;
      fsm_d   = READY;
    end else if (fsm_q == READY) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        idx = 32'(ptr_q) + i;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!found && req[idx[PTRW-1:0]]) begin
          found = 1'b1;
          gidx  = idx[PTRW-1:0];
        end
      end
      if (found) begin
        gnt_d[gidx] = 1'b1;
        rv_d        = 1'b1;
        rd_d        = mixed;
        state_d     = state_adv;
        ptr_d       = (gidx == PTRW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= AUTO_SEED ? READY : UNSEEDED;
      state_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
    end
  end

  assign gnt        = gnt_q;
  assign rand_valid = rv_q;
  assign rand_data  = rd_q;
  assign seeded     = (fsm_q == READY);

endmodule

// File: tb/tb_splitmix_arbiter.sv
// Directed self-checking bench for splitmix_arbiter (NREQ=4, AUTO_SEED=0)
// using hand-computed SplitMix64 reference values.
module tb_splitmix_arbiter;

  localparam logic [63:0] V1 = 64'hE220_A839_7B1D_CDAF;
  localparam logic [63:0] V2 = 64'h6E78_9E6A_A1B9_65F4;
  localparam logic [63:0] V3 = 64'h06C4_5D18_8009_454F;
  localparam logic [63:0] V4 = 64'hF88B_B8A8_724C_81EC;

  logic        clk;
  logic        rst_n;
  logic        seed_valid;
  logic [63:0] seed_data;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        rand_valid;
  logic [63:0] rand_data;
  logic        seeded;

  int checks;
  int failures;

  splitmix_arbiter #(.NREQ(4), .AUTO_SEED(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .req        (req),
    .gnt        (gnt),
    .rand_valid (rand_valid),
    .rand_data  (rand_data),
    .seeded     (seeded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic v,
                            input logic [63:0] d, input logic s);
    check({tag, ".gnt"},    64'(gnt), 64'(g));
    check({tag, ".valid"},  64'(rand_valid), 64'(v));
    check({tag, ".data"},   rand_data, d);
    check({tag, ".seeded"}, 64'(seeded), 64'(s));
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    seed_valid = 1'b0;
    seed_data  = '0;
    req        = '0;
    #12;
    expect_out("reset", 4'b0000, 1'b0, 64'h0, 1'b0);
    rst_n = 1'b1;

    // Unseeded: requests ignored
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("unseeded", 4'b0000, 1'b0, 64'h0, 1'b0);
    end

    // Seed with zero, no arbitration this cycle
    req        = 4'b0000;
    seed_valid = 1'b1;
    seed_data  = 64'h0;
    step();
    seed_valid = 1'b0;
    expect_out("seeded", 4'b0000, 1'b0, 64'h0, 1'b1);

    req = 4'b0001;
    step();
    expect_out("first", 4'b0001, 1'b1, V1, 1'b1);

    req = 4'b1111;
    step();
    expect_out("rr1", 4'b0010, 1'b1, V2, 1'b1);
    step();
    expect_out("rr2", 4'b0100, 1'b1, V3, 1'b1);
    step();
    expect_out("rr3", 4'b1000, 1'b1, V4, 1'b1);

    req = 4'b0000;
    step();
    expect_out("idle_hold", 4'b0000, 1'b0, V4, 1'b1);

    // Reseed with full requests: grant suppressed, then state restarts
    req        = 4'b1111;
    seed_valid = 1'b1;
    seed_data  = 64'h0;
    step();
    seed_valid = 1'b0;
    expect_out("reseed_block", 4'b0000, 1'b0, V4, 1'b1);
    step();
    expect_out("reseed_g0", 4'b0001, 1'b1, V1, 1'b1);
    step();
    expect_out("reseed_g1", 4'b0010, 1'b1, V2, 1'b1);

    // Async reset while another grant is pending
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 4'b0000, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    expect_out("post_rst", 4'b0000, 1'b0, 64'h0, 1'b0);

    req        = 4'b0000;
    seed_valid = 1'b1;
    seed_data  = 64'h0;
    step();
    seed_valid = 1'b0;
    req        = 4'b1010;
    step();
    expect_out("post_rst_g", 4'b0010, 1'b1, V1, 1'b1);

    // Requester 3 dropped; search wraps from ptr=2 to index 0
    req = 4'b0001;
    step();
    expect_out("wrap", 4'b0001, 1'b1, V2, 1'b1);

    req = 4'b0000;
    step();
    expect_out("final_idle", 4'b0000, 1'b0, V2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
